// File: rtl/relu_maxpool2x2.sv
// ReLU followed by non-overlapping 2x2 max pooling on a raster-order float16 stream.
// One pooled word per window, registered one cycle after the window's last sample.
module relu_maxpool2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oFrameDone
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LD = IMG_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_lbuf [LD];
    logic                  r_ovalid;
    logic                  r_fdone;
    logic [DATA_WIDTH-1:0] r_odata;

    logic [DATA_WIDTH-1:0] w_relu;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_lb_rd;
    logic [DATA_WIDTH-1:0] w_pool;
    logic [LW-1:0]         w_lidx;
    logic                  w_col_last;
    logic                  w_row_last;

    // After ReLU every word is non-negative, so an unsigned compare orders float16 correctly.
    assign w_relu     = iData[DATA_WIDTH-1] ? '0 : iData;
    assign w_hmax     = (w_relu > r_hold) ? w_relu : r_hold;
    assign w_lidx     = LW'(r_col >> 1);
    assign w_lb_rd    = r_lbuf[w_lidx];
    assign w_pool     = (w_hmax > w_lb_rd) ? w_hmax : w_lb_rd;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_hold   <= '0;
            r_ovalid <= 1'b0;
            r_fdone  <= 1'b0;
            r_odata  <= '0;
        end else begin
            r_ovalid <= 1'b0;
            r_fdone  <= 1'b0;
            if (iValid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end

                if (!r_col[0]) begin
                    r_hold <= w_relu;
                end else if (r_row[0]) begin
                    r_ovalid <= 1'b1;
                    r_odata  <= w_pool;
                    r_fdone  <= w_col_last && w_row_last;
                end
            end
        end
    end

    // Line buffer carries no reset: even rows always write an entry before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && iValid && r_col[0] && !r_row[0]) begin
            r_lbuf[w_lidx] <= w_hmax;
        end
    end

    assign oValid     = r_ovalid;
    assign oData      = r_odata;
    assign oFrameDone = r_fdone;

endmodule
